// File: rtl/bus_mem_target.sv
// Byte-wide memory responder for the core's m_* bus: stretches each access with m_wait,
// guards a write-protected boot region at address 0, and reads 8'hFF beyond the RAM.
module bus_mem_target #(
    parameter int    ADR_MSB     = 15,
    parameter int    MEM_AW      = 12,
    parameter int    WAIT_STATES = 0,
    parameter int    ROM_TOP     = 256,
    parameter string INIT_FILE   = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_cs,
    input  logic             m_we,
    input  logic [ADR_MSB:0] m_addr,
    input  logic [7:0]       m_odata,
    output logic [7:0]       m_idata,
    output logic             m_wait,
    output logic             prot_err
);
    localparam int            AW      = ADR_MSB + 1;
    localparam logic [AW-1:0] ROM_LIM = AW'(ROM_TOP);
    localparam logic [3:0]    WS      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           we_q, we_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q;
    logic           prot_err_q, prot_err_d;

    logic [AW-1:0]  addr_eff;
    logic           we_eff;
    logic           wr_en;
    logic [7:0]     mem_q [2**MEM_AW];

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> MEM_AW) == '0;
    endfunction

    function automatic logic is_prot(input logic [AW-1:0] a);
        return a < ROM_LIM;
    endfunction

    // In IDLE the live bus is used so a zero-wait access reads in its first cycle.
    assign addr_eff = (state_q == IDLE) ? m_addr : addr_q;
    assign we_eff   = (state_q == IDLE) ? m_we   : we_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (m_cs) begin
                    addr_d  = m_addr;
                    we_d    = m_we;
                    wdata_d = m_odata;
                    cnt_d   = WS;
                    state_d = (WS != 4'd0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (!m_cs) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        prot_err_d = (state_d == DONE) && (state_q != DONE) && we_eff
                     && (!in_range(addr_eff) || is_prot(addr_eff));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            prot_err_q <= prot_err_d;
        end
    end

    assign wr_en = !rst && (state_q == DONE) && we_q && in_range(addr_q) && !is_prot(addr_q);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_q[MEM_AW-1:0]] <= wdata_q;
        end
    end

    // Read data is held through the ack cycle so the initiator sees a stable byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else if (state_q != DONE) begin
            rdata_q <= in_range(addr_eff) ? mem_q[addr_eff[MEM_AW-1:0]] : 8'hFF;
        end
    end

    assign m_idata  = rdata_q;
    assign m_wait   = rst | (m_cs & (state_q != DONE));
    assign prot_err = prot_err_q;

endmodule

// File: tb/tb_bus_mem_target.sv
// Bench for bus_mem_target: dut0 has no wait states and a 1 KiB RAM, dut1 has 3 wait states
// and a 4 KiB RAM; both protect addresses below 0x100.
module tb_bus_mem_target;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        cs   [2];
    logic        we   [2];
    logic [15:0] addr [2];
    logic [7:0]  wd   [2];
    logic [7:0]  rd   [2];
    logic        wt   [2];
    logic        pe   [2];

    bus_mem_target #(.ADR_MSB(15), .MEM_AW(10), .WAIT_STATES(0), .ROM_TOP(256), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst[0]), .m_cs(cs[0]), .m_we(we[0]), .m_addr(addr[0]),
        .m_odata(wd[0]), .m_idata(rd[0]), .m_wait(wt[0]), .prot_err(pe[0]));

    bus_mem_target #(.ADR_MSB(15), .MEM_AW(12), .WAIT_STATES(3), .ROM_TOP(256), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst[1]), .m_cs(cs[1]), .m_we(we[1]), .m_addr(addr[1]),
        .m_odata(wd[1]), .m_idata(rd[1]), .m_wait(wt[1]), .prot_err(pe[1]));

    typedef struct {
        int          d;
        bit          w;
        logic [15:0] a;
        logic [7:0]  data;
        int          waits;
        logic [7:0]  rdv;
        bit          pev;
    } vec_t;

    typedef struct {
        logic [7:0] rdv;
        int         waits;
        bit         pev;
    } exp_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Entered and left half a cycle away from the sampling edge (just after posedge).
    task automatic access(input int d, input bit w, input logic [15:0] a, input logic [7:0] data,
                          input int exp_waits, input logic [7:0] exp_rd, input bit exp_pe,
                          input bit hold);
        exp_t e;
        int   n;
        bit   acked;
        logic [7:0] got_rd;
        logic got_pe;
        e.rdv = exp_rd; e.waits = exp_waits; e.pev = exp_pe;
        sb_q.push_back(e);
        cs[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data;
        n = 0; acked = 1'b0; got_rd = 8'h00; got_pe = 1'b0;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(negedge clk);
            if (wt[d] === 1'b0) begin
                acked = 1'b1;
                got_rd = rd[d];
                got_pe = pe[d];
            end else begin
                n++;
            end
        end
        e = sb_q.pop_front();
        if (!acked) begin
            checks++;
            errors++;
            $display("FAIL timeout d%0d a%04h: no ack within 40 cycles", d, a);
        end else begin
            $display("access d%0d %s a=%04h wd=%02h waits=%0d rd=%02h pe=%0b", d, w ? "W" : "R", a, data, n, got_rd, got_pe);
            check($sformatf("waits d%0d a%04h", d, a), n, e.waits);
            check($sformatf("prot_err d%0d a%04h", d, a), {31'd0, got_pe}, {31'd0, e.pev});
            if (!w) check($sformatf("rdata d%0d a%04h", d, a), got_rd, e.rdv);
        end
        @(posedge clk); #1;
        if (!hold) begin
            cs[d] = 1'b0;
            @(negedge clk);
            check($sformatf("pe_pulse d%0d a%04h", d, a), pe[d], 1'b0);
            check($sformatf("idle_wait d%0d", d), wt[d], 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{0, 1'b1, 16'h0100, 8'h5A, 1, 8'h00, 1'b0},
            '{0, 1'b0, 16'h0100, 8'h00, 1, 8'h5A, 1'b0},
            '{0, 1'b1, 16'h0010, 8'hAA, 1, 8'h00, 1'b1},
            '{0, 1'b0, 16'h0010, 8'h00, 1, 8'hC3, 1'b0},
            '{0, 1'b0, 16'h8000, 8'h00, 1, 8'hFF, 1'b0},
            '{0, 1'b1, 16'h8000, 8'h77, 1, 8'h00, 1'b1},
            '{0, 1'b0, 16'h0000, 8'h00, 1, 8'h11, 1'b0},
            '{0, 1'b1, 16'h03FF, 8'h3C, 1, 8'h00, 1'b0},
            '{0, 1'b0, 16'h03FF, 8'h00, 1, 8'h3C, 1'b0},
            '{0, 1'b0, 16'h0400, 8'h00, 1, 8'hFF, 1'b0},
            '{0, 1'b1, 16'h0400, 8'h99, 1, 8'h00, 1'b1},
            '{0, 1'b0, 16'h0000, 8'h00, 1, 8'h11, 1'b0},
            '{0, 1'b1, 16'h00FF, 8'h01, 1, 8'h00, 1'b1},
            '{0, 1'b0, 16'h00FF, 8'h00, 1, 8'hE7, 1'b0},
            '{1, 1'b0, 16'h0123, 8'h00, 4, 8'h9D, 1'b0},
            '{1, 1'b1, 16'h0800, 8'h66, 4, 8'h00, 1'b0},
            '{1, 1'b0, 16'h0800, 8'h00, 4, 8'h66, 1'b0},
            '{1, 1'b1, 16'h0010, 8'hAA, 4, 8'h00, 1'b1},
            '{1, 1'b0, 16'h0010, 8'h00, 4, 8'hC3, 1'b0},
            '{1, 1'b1, 16'h0100, 8'h5B, 4, 8'h00, 1'b0},
            '{1, 1'b0, 16'h0100, 8'h00, 4, 8'h5B, 1'b0}
        };

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cs[d] = 1'b0; we[d] = 1'b0; addr[d] = 16'h0000; wd[d] = 8'h00;
        end
        dut0.mem_q[0]      = 8'h11;
        dut0.mem_q[16]     = 8'hC3;
        dut0.mem_q[255]    = 8'hE7;
        dut0.mem_q[10'h200] = 8'h34;
        dut0.mem_q[10'h201] = 8'h12;
        dut1.mem_q[16]     = 8'hC3;
        dut1.mem_q[12'h123] = 8'h9D;
        dut1.mem_q[12'h900] = 8'h21;
        dut1.mem_q[12'hA00] = 8'h44;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset wait d%0d", d), wt[d], 1'b1);
            check($sformatf("reset rdata d%0d", d), rd[d], 8'h00);
            check($sformatf("reset prot_err d%0d", d), pe[d], 1'b0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        check("post-reset wait d0", wt[0], 1'b0);
        check("post-reset wait d1", wt[1], 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            access(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].data, vecs[i].waits,
                   vecs[i].rdv, vecs[i].pev, 1'b0);
        end

        // Back-to-back with m_cs held: each access must take exactly one wait cycle.
        access(0, 1'b0, 16'h0200, 8'h00, 1, 8'h34, 1'b0, 1'b1);
        access(0, 1'b0, 16'h0201, 8'h00, 1, 8'h12, 1'b0, 1'b1);
        access(0, 1'b1, 16'h0202, 8'h56, 1, 8'h00, 1'b0, 1'b1);
        access(0, 1'b0, 16'h0202, 8'h00, 1, 8'h56, 1'b0, 1'b0);

        // Reset while a write is in BUSY: no commit, m_wait forced high.
        cs[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0900; wd[1] = 8'hEE;
        @(posedge clk); @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("rst in busy wait", wt[1], 1'b1);
        @(posedge clk); #1;
        cs[1] = 1'b0;
        @(negedge clk);
        check("rst idle wait", wt[1], 1'b1);
        check("rst rdata", rd[1], 8'h00);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check("after rst wait", wt[1], 1'b0);
        check("after rst prot_err", pe[1], 1'b0);
        @(posedge clk); #1;
        access(1, 1'b0, 16'h0900, 8'h00, 4, 8'h21, 1'b0, 1'b0);

        // Abort: m_cs dropped in BUSY must not write.
        cs[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0A00; wd[1] = 8'h55;
        @(posedge clk); @(posedge clk); #1;
        cs[1] = 1'b0;
        @(negedge clk);
        check("abort wait", wt[1], 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("abort prot_err", pe[1], 1'b0);
        end
        @(posedge clk); #1;
        access(1, 1'b0, 16'h0A00, 8'h00, 4, 8'h44, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
